raster_scan_ctrl: RTL

//  Sequences one row-major raster sweep over a feature-map tile and issues one address per accepted beat.

---
 rtl/segnet_pkg.sv | 12 +
 rtl/raster_scan_ctrl_if.sv | 33 +++
 rtl/raster_scan_ctrl_scan_counter_2d.sv | 54 +++++
 rtl/raster_scan_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/segnet_pkg.sv
// Shared definitions for the raster scan controller slice.
package segnet_pkg;

    localparam int unsigned AW_DEFAULT = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/raster_scan_ctrl_if.sv
// Address beat bus between the raster scan controller and a BRAM read port.
interface raster_scan_ctrl_if
    import segnet_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) ();

    logic          addr_valid;
    logic [AW-1:0] addr;
    logic [AW-1:0] row_out;
    logic [AW-1:0] col_out;
    logic          last;
    logic          rd_ready;

    modport master (
        output addr_valid,
        output addr,
        output row_out,
        output col_out,
        output last,
        input  rd_ready
    );

    modport slave (
        input  addr_valid,
        input  addr,
        input  row_out,
        input  col_out,
        input  last,
        output rd_ready
    );

endinterface

// File: rtl/raster_scan_ctrl_scan_counter_2d.sv
// Row/column walker with incremental (multiplier-free) address generation.
module scan_counter_2d
    import segnet_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] pitch,
    input  logic [AW-1:0] rows_m1,
    input  logic [AW-1:0] cols_m1,
    output logic [AW-1:0] row,
    output logic [AW-1:0] col,
    output logic [AW-1:0] addr,
    output logic          at_end
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [AW-1:0] line_base;
    logic          at_col_end;

    assign at_col_end = (col == cols_m1);
    assign at_end     = at_col_end && (row == rows_m1);

    // Load the tile origin, then advance one element per accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            addr      <= '0;
            line_base <= '0;
        end else if (load) begin
            row       <= '0;
            col       <= '0;
            addr      <= base;
            line_base <= base;
        end else if (step) begin
            if (!at_col_end) begin
                col  <= col + ONE;
                addr <= addr + ONE;
            end else if (!at_end) begin
                col       <= '0;
                row       <= row + ONE;
                line_base <= line_base + pitch;
                addr      <= line_base + pitch;
            end
        end
    end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Raster sweep sequencer: start/abort/done control, config checking and latching.
module raster_scan_ctrl
    import segnet_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [AW-1:0]             cfg_rows,
    input  logic [AW-1:0]             cfg_cols,
    input  logic [AW-1:0]             cfg_pitch,
    input  logic [AW-1:0]             cfg_base,
    raster_scan_ctrl_if.master        rd_bus,
    output logic                      busy,
    output logic                      done,
    output logic                      err_cfg
);

    localparam logic [AW-1:0] ONE = AW'(1);

    state_t        state;
    logic          valid_q;
    logic [AW-1:0] rows_m1_q;
    logic [AW-1:0] cols_m1_q;
    logic [AW-1:0] pitch_q;
    logic          cfg_ok;
    logic          load;
    logic          step;
    logic          at_end;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] addr;

    assign cfg_ok = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_pitch >= cfg_cols);
    assign load   = (state == IDLE) && start && cfg_ok;
    assign step   = (state == RUN) && valid_q && rd_bus.rd_ready;

    scan_counter_2d #(.AW(AW)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .base    (cfg_base),
        .pitch   (pitch_q),
        .rows_m1 (rows_m1_q),
        .cols_m1 (cols_m1_q),
        .row     (row),
        .col     (col),
        .addr    (addr),
        .at_end  (at_end)
    );

    assign rd_bus.addr_valid = valid_q;
    assign rd_bus.addr       = addr;
    assign rd_bus.row_out    = row;
    assign rd_bus.col_out    = col;
    assign rd_bus.last       = valid_q && at_end;

    // Sweep FSM with registered control outputs; a final accept outranks abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cfg   <= 1'b0;
            rows_m1_q <= '0;
            cols_m1_q <= '0;
            pitch_q   <= '0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            rows_m1_q <= cfg_rows - ONE;
                            cols_m1_q <= cfg_cols - ONE;
                            pitch_q   <= cfg_pitch;
                            valid_q   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (step && at_end) begin
                        valid_q <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (abort && !step) begin
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
